// File: rtl/melody_sequencer_pkg.sv
// Shared definitions for the melody sequencer: FSM state encoding, score
// entry field layout, note-to-key decoding, note length arithmetic and the
// score ROM.
package melody_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NOTE = 2'd1,
        ST_GAP  = 2'd2,
        ST_END  = 2'd3
    } state_t;

    // Score entry layout: [7] rest, [6:4] note code, [3:0] beats-1
    localparam int REST_BIT  = 7;
    localparam int CODE_MSB  = 6;
    localparam int CODE_LSB  = 4;
    localparam int BEATS_MSB = 3;
    localparam int BEATS_LSB = 0;

    // 16 beats * 65535 clocks * 4 tempo steps = 4194240 < 2**22
    localparam int TIMER_W   = 22;
    localparam int ROM_DEPTH = 32;

    // Score ROM, listed from index 31 down to index 0.
    // Entries 0..2 are the short test phrase: n0 x2 beats, rest x1, n7 x1.
    localparam logic [ROM_DEPTH-1:0][7:0] SCORE_ROM = {
        8'h07, 8'h80, 8'h61, 8'h51, 8'h41, 8'h31, 8'h21, 8'h11,
        8'h03, 8'h81, 8'h70, 8'h60, 8'h50, 8'h40, 8'h30, 8'h20,
        8'h13, 8'h80, 8'h21, 8'h41, 8'h61, 8'h43, 8'h80, 8'h53,
        8'h41, 8'h31, 8'h21, 8'h11, 8'h03, 8'h70, 8'h80, 8'h01
    };

    // Fetch one score entry
    function automatic logic [7:0] score_entry(input logic [4:0] idx);
        return SCORE_ROM[idx];
    endfunction

    // One-hot key for an entry; rests are silent
    function automatic logic [7:0] note_key(input logic [7:0] entry);
        logic [7:0] key;
        if (entry[REST_BIT]) begin
            key = 8'h00;
        end else begin
            key = 8'h80 >> entry[CODE_MSB:CODE_LSB];
        end
        return key;
    endfunction

    // Note length in clocks: beats * tick_div * (tempo + 1)
    function automatic logic [TIMER_W-1:0] note_cycles(input logic [7:0]  entry,
                                                       input logic [15:0] tick_div,
                                                       input logic [1:0]  tempo);
        logic [TIMER_W-1:0] beats;
        logic [TIMER_W-1:0] ticks;
        logic [TIMER_W-1:0] scale;
        beats = TIMER_W'(entry[BEATS_MSB:BEATS_LSB]) + TIMER_W'(1);
        ticks = TIMER_W'(tick_div);
        scale = TIMER_W'(tempo) + TIMER_W'(1);
        return beats * ticks * scale;
    endfunction

endpackage

// File: rtl/melody_sequencer_beat_timer.sv
// Loadable down-counter shared by note and gap timing. A load of N makes
// expire assert on the N-th clock after the load edge; load wins over expiry
// so back-to-back intervals chain without a dead clock.
module melody_sequencer_beat_timer
    import melody_sequencer_pkg::*;
#(
    parameter int WIDTH = TIMER_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expire
);

    logic [WIDTH-1:0] count_reg;
    logic             running_reg;

    // Count down from load_val-1 to zero, then go idle until reloaded
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg   <= '0;
            running_reg <= 1'b0;
        end else if (clear) begin
            count_reg   <= '0;
            running_reg <= 1'b0;
        end else if (load) begin
            count_reg   <= load_val - WIDTH'(1);
            running_reg <= 1'b1;
        end else if (running_reg) begin
            if (count_reg == '0) begin
                running_reg <= 1'b0;
            end else begin
                count_reg <= count_reg - WIDTH'(1);
            end
        end
    end

    assign expire = running_reg && (count_reg == '0);

endmodule

// File: rtl/melody_sequencer.sv
// Melody sequencer: plays SONG_LEN score entries as one-hot keys with a
// silent gap between notes. Optional feature macro REPEAT_EN: loop the song
// forever (DONE pulses as playback wraps to entry 0) instead of ending.
module melody_sequencer
    import melody_sequencer_pkg::*;
#(
    parameter int TICK_DIV = 1000,
    parameter int GAP_CYC  = 200,
    parameter int SONG_LEN = 16
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       START,
    input  logic       STOP,
    input  logic [1:0] TEMPO,
    output logic [7:0] KEY,
    output logic       BUSY,
    output logic       DONE,
    output logic [4:0] NOTE_IDX
);

    state_t             state_reg;
    logic               last_entry;
    logic [4:0]         next_idx;
    logic [7:0]         next_entry;
    logic               timer_load;
    logic [TIMER_W-1:0] timer_val;
    logic               timer_expire;
    logic               timer_clear;

    // Index bookkeeping and timer load requests for the upcoming interval
    always_comb begin
        last_entry = (NOTE_IDX == 5'(SONG_LEN - 1));
        next_idx   = last_entry ? 5'd0 : NOTE_IDX + 5'd1;
        next_entry = score_entry(next_idx);
        timer_load = 1'b0;
        timer_val  = '0;
        case (state_reg)
            ST_IDLE: begin
                if (START && !STOP) begin
                    timer_load = 1'b1;
                    timer_val  = note_cycles(score_entry(5'd0), 16'(TICK_DIV), TEMPO);
                end
            end
            ST_NOTE: begin
`ifdef REPEAT_EN
                if (!STOP && timer_expire) begin
`else
                if (!STOP && timer_expire && !last_entry) begin
`endif
                    timer_load = 1'b1;
                    timer_val  = TIMER_W'(GAP_CYC);
                end
            end
            ST_GAP: begin
                if (!STOP && timer_expire) begin
                    timer_load = 1'b1;
                    timer_val  = note_cycles(next_entry, 16'(TICK_DIV), TEMPO);
                end
            end
            default: begin
            end
        endcase
    end

    assign timer_clear = STOP;

    melody_sequencer_beat_timer #(
        .WIDTH(TIMER_W)
    ) beat_timer (
        .clk     (CLK),
        .rst     (RESETN),
        .clear   (timer_clear),
        .load    (timer_load),
        .load_val(timer_val),
        .expire  (timer_expire)
    );

    // Playback FSM with registered key, index, busy and done outputs
    always_ff @(posedge CLK or posedge RESETN) begin
        if (RESETN) begin
            state_reg <= ST_IDLE;
            KEY       <= 8'h00;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            NOTE_IDX  <= 5'd0;
        end else begin
            DONE <= 1'b0;
            if (state_reg != ST_IDLE && STOP) begin
                state_reg <= ST_IDLE;
                KEY       <= 8'h00;
                BUSY      <= 1'b0;
                NOTE_IDX  <= 5'd0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (START && !STOP) begin
                            state_reg <= ST_NOTE;
                            NOTE_IDX  <= 5'd0;
                            KEY       <= note_key(score_entry(5'd0));
                            BUSY      <= 1'b1;
                        end
                    end
                    ST_NOTE: begin
                        if (timer_expire) begin
                            KEY <= 8'h00;
`ifdef REPEAT_EN
                            state_reg <= ST_GAP;
`else
                            if (last_entry) begin
                                state_reg <= ST_END;
                                DONE      <= 1'b1;
                            end else begin
                                state_reg <= ST_GAP;
                            end
`endif
                        end
                    end
                    ST_GAP: begin
                        if (timer_expire) begin
                            state_reg <= ST_NOTE;
                            NOTE_IDX  <= next_idx;
                            KEY       <= note_key(next_entry);
`ifdef REPEAT_EN
                            DONE      <= last_entry;
`endif
                        end
                    end
                    ST_END: begin
                        state_reg <= ST_IDLE;
                        BUSY      <= 1'b0;
                        NOTE_IDX  <= 5'd0;
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// Self-checking bench for melody_sequencer: directed scenarios followed by
// random START/STOP/TEMPO traffic, compared every clock against a timeline
// model built from the song description (notes, beats, gaps, end pulse).
module tb_melody_sequencer;

    localparam int TD = 4;
    localparam int GC = 2;
    localparam int SL = 3;

    logic       CLK;
    logic       RESETN;
    logic       START;
    logic       STOP;
    logic [1:0] TEMPO;
    logic [7:0] KEY;
    logic       BUSY;
    logic       DONE;
    logic [4:0] NOTE_IDX;

    melody_sequencer #(
        .TICK_DIV(TD),
        .GAP_CYC (GC),
        .SONG_LEN(SL)
    ) dut (
        .CLK     (CLK),
        .RESETN  (RESETN),
        .START   (START),
        .STOP    (STOP),
        .TEMPO   (TEMPO),
        .KEY     (KEY),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .NOTE_IDX(NOTE_IDX)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Song as written in the score: rest flag, note number, beat count
    int note_rest [SL] = '{0, 1, 0};
    int note_code [SL] = '{0, 0, 7};
    int note_beats[SL] = '{2, 1, 1};

    typedef struct packed {
        logic [7:0] key;
        logic [4:0] idx;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t sched[$];
    exp_t cur;
    bit   playing;
    int   next_note;
    bit   wrap_pending;

    int compared;
    int mismatched;
    int cycle;
    int done_cnt;
    int k80_cnt;
    int k01_cnt;

    function automatic exp_t idle_e();
        exp_t e;
        e.key  = 8'h00;
        e.idx  = 5'd0;
        e.busy = 1'b0;
        e.done = 1'b0;
        return e;
    endfunction

    function automatic logic [7:0] ref_key(int k);
        logic [7:0] one;
        one = 8'h01;
        if (note_rest[k] != 0) return 8'h00;
        return one << (7 - note_code[k]);
    endfunction

    // Append note k (length from tempo at its start) and whatever follows it
    task automatic schedule(input int k, input logic [1:0] tempo);
        int   n;
        exp_t e;
        n = note_beats[k] * TD * (int'(tempo) + 1);
        for (int i = 0; i < n; i++) begin
            e.key  = ref_key(k);
            e.idx  = 5'(k);
            e.busy = 1'b1;
            e.done = (i == 0) && wrap_pending;
            sched.push_back(e);
        end
        wrap_pending = 1'b0;
        e.key  = 8'h00;
        e.idx  = 5'(k);
        e.busy = 1'b1;
        e.done = 1'b0;
        if (k == SL - 1) begin
`ifdef REPEAT_EN
            for (int i = 0; i < GC; i++) sched.push_back(e);
            next_note    = 0;
            wrap_pending = 1'b1;
`else
            e.done = 1'b1;
            sched.push_back(e);
            next_note = -1;
`endif
        end else begin
            for (int i = 0; i < GC; i++) sched.push_back(e);
            next_note = k + 1;
        end
    endtask

    task automatic model_reset();
        playing      = 1'b0;
        wrap_pending = 1'b0;
        next_note    = -1;
        sched.delete();
        cur = idle_e();
    endtask

    // Advance the model by one rising edge with the inputs seen at that edge
    task automatic model_edge(input logic s, input logic p, input logic [1:0] t);
        if (playing && p) begin
            playing = 1'b0;
            sched.delete();
            cur = idle_e();
        end else if (playing) begin
            if (sched.size() != 0) begin
                cur = sched.pop_front();
            end else if (next_note >= 0) begin
                schedule(next_note, t);
                cur = sched.pop_front();
            end else begin
                playing = 1'b0;
                cur = idle_e();
            end
        end else if (s && !p) begin
            playing      = 1'b1;
            wrap_pending = 1'b0;
            schedule(0, t);
            cur = sched.pop_front();
        end else begin
            cur = idle_e();
        end
    endtask

    task automatic check(input string tag);
        compared++;
        assert (KEY === cur.key) else begin
            mismatched++;
            $error("FAIL %s key cyc=%0d got=%h want=%h", tag, cycle, KEY, cur.key);
        end
        compared++;
        assert (NOTE_IDX === cur.idx) else begin
            mismatched++;
            $error("FAIL %s note_idx cyc=%0d got=%0d want=%0d", tag, cycle, NOTE_IDX, cur.idx);
        end
        compared++;
        assert (BUSY === cur.busy) else begin
            mismatched++;
            $error("FAIL %s busy cyc=%0d got=%b want=%b", tag, cycle, BUSY, cur.busy);
        end
        compared++;
        assert (DONE === cur.done) else begin
            mismatched++;
            $error("FAIL %s done cyc=%0d got=%b want=%b", tag, cycle, DONE, cur.done);
        end
    endtask

    task automatic check_count(input string tag, input int got, input int want);
        compared++;
        assert (got === want) else begin
            mismatched++;
            $error("FAIL %s got=%0d want=%0d", tag, got, want);
        end
    endtask

    // One clock: drive at the falling edge, model at the rising edge, check after
    task automatic step(input logic s, input logic p, input logic [1:0] t, input string tag);
        @(negedge CLK);
        START = s;
        STOP  = p;
        TEMPO = t;
        @(posedge CLK);
        cycle++;
        model_edge(s, p, t);
        #1;
        if (DONE === 1'b1) done_cnt++;
        if (KEY === 8'h80) k80_cnt++;
        if (KEY === 8'h01) k01_cnt++;
        check(tag);
    endtask

    task automatic clear_counts();
        done_cnt = 0;
        k80_cnt  = 0;
        k01_cnt  = 0;
    endtask

    initial begin
        logic       rs;
        logic       rp;
        logic [1:0] rt;

        compared   = 0;
        mismatched = 0;
        cycle      = 0;
        clear_counts();
        model_reset();
        RESETN = 1'b1;
        START  = 1'b0;
        STOP   = 1'b0;
        TEMPO  = 2'd0;

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        check("reset");
        @(negedge CLK);
        RESETN = 1'b0;

        // Basic song at TEMPO=0
        clear_counts();
        step(1'b1, 1'b0, 2'd0, "basic");
        repeat (26) step(1'b0, 1'b0, 2'd0, "basic");
        check_count("basic_done_pulses", done_cnt, 1);
        check_count("basic_key80_clocks", k80_cnt, 8);
        check_count("basic_key01_clocks", k01_cnt, 4);

        // TEMPO=1 at start, dropped to 0 during note 0
        clear_counts();
        step(1'b1, 1'b0, 2'd1, "tempo");
        repeat (5) step(1'b0, 1'b0, 2'd1, "tempo");
        repeat (40) step(1'b0, 1'b0, 2'd0, "tempo");
        check_count("tempo_key80_clocks", k80_cnt, 16);
        check_count("tempo_key01_clocks", k01_cnt, 4);

        // STOP on clock 3 of note 0
        clear_counts();
        step(1'b1, 1'b0, 2'd0, "stop");
        repeat (2) step(1'b0, 1'b0, 2'd0, "stop");
        step(1'b0, 1'b1, 2'd0, "stop");
        step(1'b0, 1'b0, 2'd0, "stop");
        repeat (20) step(1'b0, 1'b0, 2'd0, "stop");
        check_count("stop_done_pulses", done_cnt, 0);

        // START re-pulsed during the first gap is ignored
        clear_counts();
        step(1'b1, 1'b0, 2'd0, "regap");
        repeat (8) step(1'b0, 1'b0, 2'd0, "regap");
        step(1'b1, 1'b0, 2'd0, "regap");
        repeat (20) step(1'b0, 1'b0, 2'd0, "regap");
        check_count("regap_done_pulses", done_cnt, 1);
        check_count("regap_key80_clocks", k80_cnt, 8);

        // START with STOP in idle stays idle
        repeat (3) step(1'b1, 1'b1, 2'd0, "startstop");
        step(1'b0, 1'b0, 2'd0, "startstop");

        // START held through END restarts from entry 0
        clear_counts();
        repeat (30) step(1'b1, 1'b0, 2'd0, "hold");
        check_count("hold_done_pulses", done_cnt, 1);
        step(1'b0, 1'b1, 2'd0, "hold");
        step(1'b0, 1'b0, 2'd0, "hold");

        // Asynchronous reset in the middle of note 0
        step(1'b1, 1'b0, 2'd0, "areset");
        repeat (3) step(1'b0, 1'b0, 2'd0, "areset");
        @(negedge CLK);
        #2;
        RESETN = 1'b1;
        model_reset();
        #1;
        check("areset_now");
        @(posedge CLK);
        #1;
        check("areset_held");
        @(negedge CLK);
        RESETN = 1'b0;
        repeat (3) step(1'b0, 1'b0, 2'd0, "areset");

        // Random traffic
        rt = 2'd0;
        for (int i = 0; i < 2000; i++) begin
            rs = ($urandom_range(0, 15) == 0);
            rp = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 19) == 0) rt = 2'($urandom_range(0, 3));
            step(rs, rp, rt, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/melody_sequencer.md
MELODY_SEQUENCER -- requirements
Module: melody_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1000: clocks per beat at TEMPO=0, range 2..65535.
REQ-002 SHALL have parameter GAP_CYC, default 200: silent clocks between consecutive notes, range 1..65535.
REQ-003 SHALL have parameter SONG_LEN, default 16: number of score entries played, range 1..32.
REQ-004 SHALL have port CLK  input  1  system clock; all state changes on its rising edge.
REQ-005 SHALL have port RESETN  input  1  reset; asynchronous and active-high.
REQ-006 SHALL have port START  input  1  level-sampled request to begin playback from entry 0.
REQ-007 SHALL have port STOP  input  1  abort playback.
REQ-008 SHALL have port TEMPO  input  2  beat length select; beat = TICK_DIV*(TEMPO+1) clocks.
REQ-009 SHALL have port KEY  output  8  one-hot note code to the tone generator; 0 = silence.
REQ-010 SHALL have port BUSY  output  1  high while not IDLE.
REQ-011 SHALL have port DONE  output  1  one-clock pulse at natural end of song.
REQ-012 SHALL have port NOTE_IDX  output  5  index of the current score entry.

Function
REQ-013 Score entry SHALL be 8 bits: [7] rest flag, [6:4] note code n, [3:0] beats-1 (1..16 beats).
REQ-014 Non-rest entry SHALL drive KEY = 8'b10000000 >> n (n=0 -> 8'b10000000, n=7 -> 8'b00000001); rest entry SHALL drive KEY = 0.
REQ-015 FSM states SHALL be IDLE, NOTE, GAP, END.
REQ-016 IDLE: START=1 and STOP=0 -> NOTE with NOTE_IDX=0 and KEY from entry 0 in the next clock.
REQ-017 NOTE SHALL last exactly (beats)*TICK_DIV*(TEMPO+1) clocks; TEMPO sampled on entry to NOTE and held for that note.
REQ-018 NOTE expiry, not last entry -> GAP; KEY=0 for exactly GAP_CYC clocks -> NOTE with NOTE_IDX+1.
REQ-019 NOTE expiry, last entry (NOTE_IDX=SONG_LEN-1) -> END without a gap; END lasts one clock with DONE=1, KEY=0, then IDLE.
REQ-020 STOP=1 in any non-IDLE state SHALL force IDLE next clock with KEY=0, NOTE_IDX=0, and no DONE pulse.
REQ-021 START while BUSY SHALL be ignored; START and STOP together in IDLE SHALL leave the block in IDLE.
REQ-022 START held high after END SHALL restart playback from entry 0 in the clock after the return to IDLE.
REQ-023 Beat and gap counters SHALL be wide enough for 16*65535*4 clocks without wrap.
REQ-024 KEY SHALL be registered and change only on state or entry transitions.

Reset
REQ-025 RESETN=1 SHALL asynchronously force IDLE, KEY=0, BUSY=0, DONE=0, NOTE_IDX=0, and clear all counters.

Configuration
REQ-026 With REPEAT_EN defined, last-entry expiry SHALL go to GAP then NOTE with NOTE_IDX=0, pulsing DONE for one clock on the wrap; playback ends only via STOP.
REQ-027 With REPEAT_EN undefined, REQ-019 behaviour SHALL apply.

Structure
REQ-028 Shared package SHALL hold the state encoding, the entry field positions, the note-code-to-one-hot function, and the score ROM constant.
REQ-029 Sub-module beat_timer SHALL be used: a loadable down-counter with load/expire handshake, used for both NOTE and GAP timing.

Verification (TICK_DIV=4, GAP_CYC=2, SONG_LEN=3, score {n0 2 beats, rest 1 beat, n7 1 beat})
REQ-030 START pulse at TEMPO=0: KEY=8'h80 for 8 clocks, then 0 for 2, then 0 for 4, then 0 for 2, then 8'h01 for 4; DONE pulses once; BUSY falls the clock after DONE.
REQ-031 TEMPO=1 changed to 0 mid-note 0: note 0 still lasts 16 clocks; note 2 lasts 4 clocks.
REQ-032 STOP at clock 3 of note 0: KEY=0 and BUSY=0 next clock; DONE never asserts.
REQ-033 START re-pulsed during GAP: sequence identical to REQ-030; START and STOP together in IDLE: BUSY stays 0.
REQ-034 RESETN asserted mid-NOTE, asynchronously to CLK: KEY=0 and NOTE_IDX=0 immediately, without waiting for a clock edge.
REQ-035 REPEAT_EN defined: after note 2, 2 gap clocks, then KEY=8'h80 with NOTE_IDX=0; DONE pulses once per pass.
